// File: rtl/ecap5_dwbinterconnect_pkg.sv
// Shared types and constants for the ecap5 data-side Wishbone interconnect.
package ecap5_dwbinterconnect_pkg;

    // Slave index wide enough for 16 slaves plus a distinct NULL code.
    typedef logic [4:0] slave_idx_t;
    localparam slave_idx_t SLAVE_NULL = 5'd16;

    // Interconnect state is derived from the outstanding count.
    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_BUSY = 1'b1;

    localparam logic [4*32-1:0] DEFAULT_BASE =
        {32'hC000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000};
    localparam logic [4*32-1:0] DEFAULT_MASK = {4{32'hC000_0000}};

    localparam logic [31:0] TIMEOUT_DATA = 32'hDEAD_BEEF;

endpackage

// File: rtl/ecap5_dwbinterconnect_decoder.sv
// Combinational base/mask address decoder; lowest-index hit wins, no hit gives SLAVE_NULL.
module ecap5_dwbinterconnect_decoder
    import ecap5_dwbinterconnect_pkg::*;
#(
    parameter int unsigned               NB_SLAVES  = 4,
    parameter logic [NB_SLAVES*32-1:0]   SLAVE_BASE = DEFAULT_BASE,
    parameter logic [NB_SLAVES*32-1:0]   SLAVE_MASK = DEFAULT_MASK
) (
    input  logic [31:0] adr_i,
    output slave_idx_t  idx_o,
    output logic        hit_o
);

    // Scan from the top so the lowest matching index is the last one written.
    always_comb begin
        idx_o = SLAVE_NULL;
        hit_o = 1'b0;
        for (int i = NB_SLAVES - 1; i >= 0; i--) begin
            if ((adr_i & SLAVE_MASK[32*i +: 32]) == SLAVE_BASE[32*i +: 32]) begin
                idx_o = slave_idx_t'(i);
                hit_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/ecap5_dwbinterconnect.sv
// Wishbone B4 pipelined 1-master / NB_SLAVES-slave interconnect with outstanding tracking,
// drain-before-switch and an internal null responder for unmapped addresses.
// Optional watchdog enabled by defining ECAP5_DWBINTERCONNECT_TIMEOUT_EN.
module ecap5_dwbinterconnect
    import ecap5_dwbinterconnect_pkg::*;
#(
    parameter int unsigned             NB_SLAVES       = 4,
    parameter logic [NB_SLAVES*32-1:0] SLAVE_BASE      = DEFAULT_BASE,
    parameter logic [NB_SLAVES*32-1:0] SLAVE_MASK      = DEFAULT_MASK,
    parameter int unsigned             MAX_OUTSTANDING = 4,
    parameter int unsigned             TIMEOUT_CYCLES  = 1024
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic [31:0]             wb_adr_i,
    input  logic [31:0]             wb_dat_i,
    output logic [31:0]             wb_dat_o,
    input  logic [3:0]              wb_sel_i,
    input  logic                    wb_we_i,
    input  logic                    wb_stb_i,
    input  logic                    wb_cyc_i,
    output logic                    wb_ack_o,
    output logic                    wb_stall_o,
    output logic [NB_SLAVES*32-1:0] s_wb_adr_o,
    output logic [NB_SLAVES*32-1:0] s_wb_dat_o,
    input  logic [NB_SLAVES*32-1:0] s_wb_dat_i,
    output logic [NB_SLAVES*4-1:0]  s_wb_sel_o,
    output logic [NB_SLAVES-1:0]    s_wb_we_o,
    output logic [NB_SLAVES-1:0]    s_wb_stb_o,
    output logic [NB_SLAVES-1:0]    s_wb_cyc_o,
    input  logic [NB_SLAVES-1:0]    s_wb_ack_i,
    input  logic [NB_SLAVES-1:0]    s_wb_stall_i
);

    localparam int unsigned CntW = $clog2(MAX_OUTSTANDING + 1);

    slave_idx_t      active_q, active_d;
    logic [CntW-1:0] count_q, count_d;
    logic            null_ack_q, null_ack_d;

    slave_idx_t  tgt_idx;
    logic        tgt_hit;
    logic        tgt_stall;
    logic        act_ack;
    logic [31:0] act_dat;
    logic [0:0]  state;
    logic        busy;
    logic        full;
    logic        ack_raw;
    logic        timeout;
    logic        switch_pending;
    logic        stall;
    logic        req;
    logic        accept;
    logic        issue;

    ecap5_dwbinterconnect_decoder #(
        .NB_SLAVES  (NB_SLAVES),
        .SLAVE_BASE (SLAVE_BASE),
        .SLAVE_MASK (SLAVE_MASK)
    ) u_decoder (
        .adr_i (wb_adr_i),
        .idx_o (tgt_idx),
        .hit_o (tgt_hit)
    );

    assign state = (count_q != '0) ? ST_BUSY : ST_IDLE;
    assign busy  = (state == ST_BUSY);
    assign full  = (count_q == CntW'(MAX_OUTSTANDING));

    // Look up the target's stall and the active slave's ack/data by index.
    always_comb begin
        tgt_stall = 1'b0;
        act_ack   = null_ack_q;
        act_dat   = '0;
        for (int i = 0; i < NB_SLAVES; i++) begin
            if (tgt_idx == slave_idx_t'(i)) begin
                tgt_stall = s_wb_stall_i[i];
            end
            if (active_q == slave_idx_t'(i)) begin
                act_ack = s_wb_ack_i[i];
                act_dat = s_wb_dat_i[32*i +: 32];
            end
        end
    end

    // Acks only count while a request is outstanding and the master still holds cyc.
    assign ack_raw = busy & wb_cyc_i & act_ack;

`ifdef ECAP5_DWBINTERCONNECT_TIMEOUT_EN
    localparam int unsigned WdW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic [WdW-1:0] wd_q, wd_d;

    assign timeout = busy & wb_cyc_i & ~ack_raw & (wd_q == WdW'(TIMEOUT_CYCLES - 1));

    // Watchdog counts busy cycles without an ack and restarts on any ack.
    always_comb begin
        wd_d = wd_q + 1'b1;
        if (!busy || !wb_cyc_i || ack_raw || timeout) begin
            wd_d = '0;
        end
    end

    // Watchdog register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wd_q <= '0;
        end else begin
            wd_q <= wd_d;
        end
    end
`else
    assign timeout = 1'b0;

    logic unused_timeout_cfg;
    assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
`endif

    // Handshake: stall, acceptance, forwarding and next-state.
    always_comb begin
        switch_pending = busy && (tgt_idx != active_q);
        stall          = switch_pending | full | tgt_stall | timeout;
        req            = wb_cyc_i & wb_stb_i;
        accept         = req & ~stall & ~rst_i;
        // Strobe reaches the target whenever the interconnect itself is not holding it back;
        // the slave's own stall then decides acceptance.
        issue          = req & ~switch_pending & ~full & ~timeout & ~rst_i;

        count_d = count_q;
        if (accept && !ack_raw) begin
            count_d = count_q + 1'b1;
        end else if (!accept && ack_raw) begin
            count_d = count_q - 1'b1;
        end
        if (!wb_cyc_i || timeout) begin
            count_d = '0;
        end

        active_d   = accept ? tgt_idx : active_q;
        null_ack_d = accept & ~tgt_hit;
    end

    // Master and slave port drive.
    always_comb begin
        wb_stall_o = stall & ~rst_i;
        wb_ack_o   = (ack_raw | timeout) & ~rst_i;
        wb_dat_o   = rst_i ? 32'h0 : (timeout ? TIMEOUT_DATA : act_dat);
        for (int i = 0; i < NB_SLAVES; i++) begin
            s_wb_adr_o[32*i +: 32] = wb_adr_i & ~SLAVE_MASK[32*i +: 32];
            s_wb_dat_o[32*i +: 32] = wb_dat_i;
            s_wb_sel_o[4*i +: 4]   = wb_sel_i;
            s_wb_we_o[i]           = wb_we_i;
            s_wb_stb_o[i]          = issue & tgt_hit & (tgt_idx == slave_idx_t'(i));
            s_wb_cyc_o[i]          = wb_cyc_i & ~rst_i & ~timeout &
                                     ((busy & (active_q == slave_idx_t'(i))) | s_wb_stb_o[i]);
        end
    end

    // Interconnect state registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            active_q   <= slave_idx_t'(0);
            count_q    <= '0;
            null_ack_q <= 1'b0;
        end else begin
            active_q   <= active_d;
            count_q    <= count_d;
            null_ack_q <= null_ack_d;
        end
    end

endmodule
